// File: rtl/ft6206_i2c_target.sv
// I2C target emulating the FT6206 register interface; bus events act 3 clk after the pins (5 with FT6206_TARGET_GLITCH_FILTER_EN).
// Never stretches SCL; sda is open-drain (0 or z only); reads come from a snapshot taken at the address phase.
module ft6206_i2c_target #(
    parameter int         CLK_HZ      = 12_000_000,
    parameter logic [6:0] TARGET_ADDR = 7'h38,
    parameter int         N_REGS      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    inout  wire                 sda,
    input  logic [N_REGS*8-1:0] reg_image,
    output logic                wr_valid,
    output logic [7:0]          wr_addr,
    output logic [7:0]          wr_data,
    output logic                busy,
    output logic                rd_done
);

    if (CLK_HZ < 2_000_000) begin : g_clk_check
        $error("CLK_HZ too low for a 100 kHz bus");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_PTR, S_WR_DATA, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_f, sda_f;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                ack_ph_q, ack_ph_d;
    logic                rw_q, rw_d;
    logic [7:0]          ptr_q, ptr_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                wr_valid_q, wr_valid_d;
    logic [7:0]          wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                rd_done_q, rd_done_d;
    logic [N_REGS*8-1:0] snap_q, snap_d;
    logic [7:0]          rd_byte;
    logic                rise, fall, start, stop;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl};
        sda_sync_d = {sda_sync_q[0], sda};
    end

`ifdef FT6206_TARGET_GLITCH_FILTER_EN
    // A level is accepted once the synced sample and the two before it agree.
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_hold_q, sda_hold_q;

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_f = (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1]) ? scl_sync_q[1] : scl_hold_q;
        sda_f = (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1]) ? sda_sync_q[1] : sda_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_hold_q <= 1'b1;
            sda_hold_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_hold_q <= scl_f;
            sda_hold_q <= sda_f;
        end
    end
`else
    always_comb begin
        scl_f = scl_sync_q[1];
        sda_f = sda_sync_q[1];
    end
`endif

    always_comb begin
        scl_prev_d = scl_f;
        sda_prev_d = sda_f;
        rise  = scl_f & ~scl_prev_q;
        fall  = ~scl_f & scl_prev_q;
        start = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
        stop  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    end

    // Pointers past the image read as zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < N_REGS; i++) begin
            if (int'(ptr_q) == i) rd_byte = snap_q[i*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ack_ph_d   = ack_ph_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_done_d  = 1'b0;
        snap_d     = snap_q;

        if (start) begin
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
        end else if (stop) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_WR_PTR, S_WR_DATA: begin
                    if (rise && cnt_q < 4'd8) begin
                        shreg_d = {shreg_q[6:0], sda_f};
                        cnt_d   = cnt_q + 4'd1;
                    end
                    if (fall && ack_ph_q) begin
                        // End of the ACK clock: only now is the byte committed.
                        ack_ph_d = 1'b0;
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = S_WR_DATA;
                        if (state_q == S_WR_PTR) begin
                            ptr_d = shreg_q;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shreg_q;
                            ptr_d      = ptr_q + 8'd1;
                        end
                    end else if (fall && cnt_q == 4'd8) begin
                        if (state_q != S_ADDR) begin
                            ack_ph_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end else if (shreg_q[7:1] == TARGET_ADDR) begin
                            busy_d   = 1'b1;
                            sda_oe_d = 1'b1;
                            rw_d     = shreg_q[0];
                            state_d  = S_ADDR_ACK;
                            if (shreg_q[0]) snap_d = reg_image;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            shreg_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            state_d  = S_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_WR_PTR;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (rise && cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                    if (fall && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_RD_ACK;
                    end else if (fall && cnt_q != 4'd0) begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        sda_oe_d = ~shreg_q[6];
                    end
                end
                S_RD_ACK: begin
                    if (rise && cnt_q == 4'd8) begin
                        ptr_d = ptr_q + 8'd1;
                        cnt_d = 4'd9;
                        if (sda_f) begin
                            rd_done_d = 1'b1;
                            state_d   = S_IGNORE;
                        end
                    end else if (fall && cnt_q == 4'd9) begin
                        cnt_d    = 4'd0;
                        shreg_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        state_d  = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shreg_q    <= 8'h00;
            ack_ph_q   <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= 8'h00;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            rd_done_q  <= 1'b0;
            snap_q     <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ack_ph_q   <= ack_ph_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_done_q  <= rd_done_d;
            snap_q     <= snap_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign rd_done  = rd_done_q;

endmodule
